// File: rtl/seg_scan_if.sv
// seg_scan_if: pattern load and display drive bundle for seg_scan_driver.
// The slave side is the scanner; the master side feeds patterns and watches the pins.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 8
) ();

  logic [7*NUM_DIGITS-1:0] seg_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load;
  logic                    load_ack;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_start;

  modport master (
    output seg_in,
    output dp_in,
    output digit_en,
    output load,
    input  load_ack,
    input  an,
    input  seg,
    input  dp,
    input  frame_start
  );

  modport slave (
    input  seg_in,
    input  dp_in,
    input  digit_en,
    input  load,
    output load_ack,
    output an,
    output seg,
    output dp,
    output frame_start
  );

endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed active-low 7-seg scanner with dead-time
// blanking and frame-aligned commit of pending patterns.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic       clk,
  input logic       rst_n,
  seg_scan_if.slave bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int SW = 7 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    BLANK,
    DRIVE
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  pending;
  logic [SW-1:0]         pend_seg;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [SW-1:0]         disp_seg;
  logic [NUM_DIGITS-1:0] disp_dp;

  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic                  ack_q;
  logic                  fs_q;

  logic                  cnt_wrap;
  logic                  boundary;
  logic [CW-1:0]         cnt_nxt;
  logic [IW-1:0]         idx_nxt;
  state_t                state_nxt;

  logic                  lit;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  always_comb begin
    cnt_wrap = (cnt == CNT_LAST);
    cnt_nxt  = cnt_wrap ? '0 : cnt + 1'b1;
    idx_nxt  = idx;
    if (cnt_wrap) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
    boundary  = (cnt == '0) && (idx == '0);
    state_nxt = (cnt_nxt < CNT_BLANK) ? BLANK : DRIVE;
  end

  // Disabled digits look exactly like dead-time on the pins.
  always_comb begin
    lit     = 1'b0;
    an_nxt  = '1;
    seg_nxt = '1;
    dp_nxt  = 1'b1;
    unique case (state)
      BLANK: lit = 1'b0;
      DRIVE: lit = bus.digit_en[idx];
    endcase
    if (lit) begin
      an_nxt[idx] = 1'b0;
      seg_nxt     = disp_seg[int'(idx)*7 +: 7];
      dp_nxt      = ~disp_dp[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BLANK;
      cnt      <= '0;
      idx      <= '0;
      pending  <= 1'b0;
      pend_seg <= '1;
      pend_dp  <= '0;
      disp_seg <= '1;
      disp_dp  <= '0;
      an_q     <= '1;
      seg_q    <= '1;
      dp_q     <= 1'b1;
      ack_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;

      an_q  <= an_nxt;
      seg_q <= seg_nxt;
      dp_q  <= dp_nxt;
      fs_q  <= boundary;
      ack_q <= boundary && pending;

      // Commit lands in digit 0 dead-time, so no frame is ever torn.
      if (boundary && pending) begin
        disp_seg <= pend_seg;
        disp_dp  <= pend_dp;
      end

      if (bus.load) begin
        pend_seg <= bus.seg_in;
        pend_dp  <= bus.dp_in;
        pending  <= 1'b1;
      end else if (boundary) begin
        pending  <= 1'b0;
      end
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.load_ack    = ack_q;
  assign bus.frame_start = fs_q;

  always @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(~an_q));
    end
  end

endmodule
